// File: rtl/data_memory_controller_pkg.sv
// Shared definitions for the data memory controller.
// Contents:
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD  access size encodings (2'b11 acts as word)
//   dmc_state_t                        controller FSM state
//   byte_enable(size, offset)          big-endian write lane mask
//   misaligned(size, offset)           alignment check for a request
//   store_data(size, data)             lane-replicated store operand
package dmc_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_WR_WAIT,
    S_DONE
  } dmc_state_t;

  // Big-endian lanes: byte offset 0 lives in bits [31:24], i.e. lane 3.
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b1000 >> offset;
      SIZE_HALF: return offset[1] ? 4'b0011 : 4'b1100;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      default:   return offset != 2'b00;
    endcase
  endfunction

  // Sub-word stores are replicated across the word so the memory only has
  // to honour the lane mask, independent of where the byte/half lands.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_controller_load_aligner.sv
// Load aligner: picks the addressed byte or half out of a big-endian memory
// word and sign- or zero-extends it to 32 bits. Purely combinational.
// Ports:
//   word        in  32  word returned by memory
//   offset      in  2   byte offset of the access within the word
//   size        in  2   access size (dmc_pkg encodings)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  aligned, extended load value
module load_aligner
  import dmc_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        fill;

  always_comb begin
    sel_byte = 8'h00;
    sel_half = offset[1] ? word[15:0] : word[31:16];
    fill     = 1'b0;
    result   = word;
    case (offset)
      2'd0:    sel_byte = word[31:24];
      2'd1:    sel_byte = word[23:16];
      2'd2:    sel_byte = word[15:8];
      default: sel_byte = word[7:0];
    endcase
    case (size)
      SIZE_BYTE: begin
        fill   = ~is_unsigned & sel_byte[7];
        result = {{24{fill}}, sel_byte};
      end
      SIZE_HALF: begin
        fill   = ~is_unsigned & sel_half[15];
        result = {{16{fill}}, sel_half};
      end
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// Data memory controller: MEM-stage initiator for the word-wide data memory.
// Registers a load/store request, drives the strobe/Ack handshake, stalls the
// pipeline until the access retires, and returns an aligned load result.
// Misaligned requests and Ack timeouts complete with an error flag instead of
// hanging the pipeline.
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   MemRead/MemWrite  load/store request (write wins when both are high)
//   MemSize           00 byte, 01 half, 10/11 word
//   MemUnsigned       zero-extend sub-word loads
//   Address           byte address
//   StoreData         store operand (low byte/half used for sub-word stores)
//   Stall             freeze pipeline while the access is in flight
//   LoadData          aligned load result, valid in the DONE cycle
//   AddressError      misaligned request, valid in the DONE cycle
//   BusError          Ack timeout, valid in the DONE cycle
//   DmAddress, DmWriteData, DmWriteEnable, DmReadEnable, DmByteEnable
//                     registered memory-side request
//   DmAck, DmReadData memory completion and read word
module data_memory_controller
  import dmc_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        AddressError,
  output logic        BusError,
  output logic [31:0] DmAddress,
  output logic [31:0] DmWriteData,
  output logic        DmWriteEnable,
  output logic        DmReadEnable,
  output logic [3:0]  DmByteEnable,
  input  logic        DmAck,
  input  logic [31:0] DmReadData
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  // The counter starts at 0 in the first waiting cycle, so giving up when it
  // sits at ACK_TIMEOUT-1 yields exactly ACK_TIMEOUT waiting cycles.
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  dmc_state_t    state;
  logic [CW-1:0] wait_count;
  logic [1:0]    size_q;
  logic          unsigned_q;
  logic [31:0]   read_word;
  logic          request;

  assign request = MemRead | MemWrite;

  // Stall is gated by RST_N so a held request cannot keep the pipeline frozen
  // while the controller is in reset.
  assign Stall = RST_N & (((state == S_IDLE) & request) |
                          (state == S_RD) | (state == S_WR) | (state == S_WR_WAIT));

  load_aligner u_load_aligner (
    .word       (read_word),
    .offset     (DmAddress[1:0]),
    .size       (size_q),
    .is_unsigned(unsigned_q),
    .result     (LoadData)
  );

  // Controller FSM; every memory-side output and error flag is registered here.
  // read_word is cleared on acceptance and on timeout so LoadData reads 0
  // whenever no memory data was captured for the current access.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= S_IDLE;
      wait_count    <= '0;
      size_q        <= SIZE_WORD;
      unsigned_q    <= 1'b0;
      read_word     <= '0;
      AddressError  <= 1'b0;
      BusError      <= 1'b0;
      DmAddress     <= '0;
      DmWriteData   <= '0;
      DmWriteEnable <= 1'b0;
      DmReadEnable  <= 1'b0;
      DmByteEnable  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (request) begin
            DmAddress   <= Address;
            DmWriteData <= store_data(MemSize, StoreData);
            size_q      <= MemSize;
            unsigned_q  <= MemUnsigned;
            read_word   <= '0;
            wait_count  <= '0;
            if (misaligned(MemSize, Address[1:0])) begin
              AddressError <= 1'b1;
              DmByteEnable <= '0;
              state        <= S_DONE;
            end else begin
              DmByteEnable <= byte_enable(MemSize, Address[1:0]);
              if (MemWrite) begin
                DmWriteEnable <= 1'b1;
                state         <= S_WR;
              end else begin
                DmReadEnable <= 1'b1;
                state        <= S_RD;
              end
            end
          end
        end
        S_WR: begin
          DmWriteEnable <= 1'b0;
          wait_count    <= '0;
          state         <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (DmAck) begin
            state <= S_DONE;
          end else if (wait_count == LAST) begin
            BusError <= 1'b1;
            state    <= S_DONE;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        S_RD: begin
          if (DmAck) begin
            read_word    <= DmReadData;
            DmReadEnable <= 1'b0;
            state        <= S_DONE;
          end else if (wait_count == LAST) begin
            read_word    <= '0;
            DmReadEnable <= 1'b0;
            BusError     <= 1'b1;
            state        <= S_DONE;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        S_DONE: begin
          AddressError <= 1'b0;
          BusError     <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
